// File: rtl/alu_pkg.sv
// Shared opcode and condition-mode encodings for the pipelined integer ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_NAND = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;

    localparam logic [1:0] CZ_ALWAYS = 2'b00;
    localparam logic [1:0] CZ_IF_Z   = 2'b01;
    localparam logic [1:0] CZ_IF_C   = 2'b10;
    localparam logic [1:0] CZ_ADC    = 2'b11;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_NAND) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: decode, condition evaluation, add/sub/nand and flag/write-enable generation.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
) (
    input  logic [3:0]        opcode,
    input  logic [1:0]        cz,
    input  logic              cmp,
    input  logic              carry_in,
    input  logic              zero_in,
    input  logic [DATA_W-1:0] opr1,
    input  logic [DATA_W-1:0] opr2,
    input  logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] result,
    output logic [PC_W-1:0]   pc_next,
    output logic              exec,
    output logic              illegal,
    output logic              carry,
    output logic              zero,
    output logic              c_wr,
    output logic              z_wr
);

    logic [DATA_W:0] sum;
    logic            cond;
    logic            is_arith;
    logic            adc_cin;

    always_comb begin
        illegal  = !is_legal_op(opcode);
        is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

        case (cz)
            CZ_IF_Z: cond = zero_in;
            CZ_IF_C: cond = carry_in;
            default: cond = 1'b1;
        endcase
        exec = !illegal && cond;

        // carry-in only applies to ADD in ADC mode; SUB uses two's complement with bit DATA_W = no borrow
        adc_cin = (opcode == OP_ADD) && (cz == CZ_ADC) && carry_in;
        if (opcode == OP_SUB)
            sum = {1'b0, opr1} + {1'b0, ~opr2} + (DATA_W+1)'(1);
        else
            sum = {1'b0, opr1} + {1'b0, opr2} + (DATA_W+1)'(adc_cin);

        result = '0;
        carry  = 1'b0;
        if (exec) begin
            result = (opcode == OP_NAND) ? ~(opr1 & opr2) : sum[DATA_W-1:0];
            carry  = is_arith && sum[DATA_W];
        end
        zero    = exec && (result == '0);
        z_wr    = exec && cmp;
        c_wr    = exec && cmp && is_arith;
        pc_next = pc + PC_W'(1);
    end

endmodule

// File: rtl/alu_pipe_gen.sv
// Two-stage pipelined ALU: S1 holds the issued instruction, S2 holds the computed result for the CDB.
module alu_pipe_gen
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [3:0]        opcode_in,
    input  logic [DATA_W-1:0] opr1_in,
    input  logic [DATA_W-1:0] opr2_in,
    input  logic [TAG_W-1:0]  rrf_dest_in,
    input  logic [1:0]        cz_in,
    input  logic              cmp_in,
    input  logic              carry_in,
    input  logic              zero_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic [3:0]        opcode_out,
    output logic [TAG_W-1:0]  rrf_dest_out,
    output logic [DATA_W-1:0] result,
    output logic [PC_W-1:0]   pc_next,
    output logic              exec_out,
    output logic              illegal_out,
    output logic              carry_out,
    output logic              zero_out,
    output logic              c_wr,
    output logic              z_wr
);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [3:0]        opcode;
        logic [DATA_W-1:0] opr1;
        logic [DATA_W-1:0] opr2;
        logic [TAG_W-1:0]  tag;
        logic [1:0]        cz;
        logic              cmp;
        logic              cin;
        logic              zin;
    } s1_t;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [3:0]        opcode;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] result;
        logic [PC_W-1:0]   pc_next;
        logic              exec;
        logic              illegal;
        logic              carry;
        logic              zero;
        logic              c_wr;
        logic              z_wr;
    } s2_t;

    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic rdy_q, rdy_d;
    logic s2_adv, accept;

    logic [DATA_W-1:0] core_result;
    logic [PC_W-1:0]   core_pc_next;
    logic core_exec, core_illegal, core_carry, core_zero, core_c_wr, core_z_wr;

    alu_core #(.DATA_W(DATA_W), .PC_W(PC_W)) u_core (
        .opcode   (s1_q.opcode),
        .cz       (s1_q.cz),
        .cmp      (s1_q.cmp),
        .carry_in (s1_q.cin),
        .zero_in  (s1_q.zin),
        .opr1     (s1_q.opr1),
        .opr2     (s1_q.opr2),
        .pc       (s1_q.pc),
        .result   (core_result),
        .pc_next  (core_pc_next),
        .exec     (core_exec),
        .illegal  (core_illegal),
        .carry    (core_carry),
        .zero     (core_zero),
        .c_wr     (core_c_wr),
        .z_wr     (core_z_wr)
    );

    always_comb begin
        // rdy_q keeps in_ready low from reset until the first clock edge after release
        rdy_d    = 1'b1;
        s2_adv   = !s2_valid_q || out_ready;
        in_ready = rdy_q && (!s1_valid_q || s2_adv);
        accept   = in_valid && in_ready && !flush;

        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid_d = s1_valid_q;
                s2_d = '{pc: s1_q.pc, opcode: s1_q.opcode, tag: s1_q.tag,
                         result: core_result, pc_next: core_pc_next,
                         exec: core_exec, illegal: core_illegal,
                         carry: core_carry, zero: core_zero,
                         c_wr: core_c_wr, z_wr: core_z_wr};
            end
            if (!s1_valid_q || s2_adv) begin
                s1_valid_d = accept;
                s1_d = '{pc: pc_in, opcode: opcode_in, opr1: opr1_in, opr2: opr2_in,
                         tag: rrf_dest_in, cz: cz_in, cmp: cmp_in,
                         cin: carry_in, zin: zero_in};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            rdy_q      <= rdy_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign pc_out       = s2_q.pc;
    assign opcode_out   = s2_q.opcode;
    assign rrf_dest_out = s2_q.tag;
    assign result       = s2_q.result;
    assign pc_next      = s2_q.pc_next;
    assign exec_out     = s2_q.exec;
    assign illegal_out  = s2_q.illegal;
    assign carry_out    = s2_q.carry;
    assign zero_out     = s2_q.zero;
    assign c_wr         = s2_q.c_wr;
    assign z_wr         = s2_q.z_wr;

endmodule

// File: tb/tb_alu_pipe_gen.sv
// Self-checking bench for alu_pipe_gen: directed vectors, an arithmetic reference model and a scoreboard.
module tb_alu_pipe_gen;

    localparam int DW = 16;
    localparam int PW = 16;
    localparam int TW = 5;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, flush, out_valid, out_ready;
    logic [PW-1:0] pc_in, pc_out, pc_next;
    logic [3:0]    opcode_in, opcode_out;
    logic [DW-1:0] opr1_in, opr2_in, result;
    logic [TW-1:0] rrf_dest_in, rrf_dest_out;
    logic [1:0]    cz_in;
    logic cmp_in, carry_in, zero_in;
    logic exec_out, illegal_out, carry_out, zero_out, c_wr, z_wr;

    always #5 clk = ~clk;

    alu_pipe_gen #(.DATA_W(DW), .PC_W(PW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .opcode_in(opcode_in), .opr1_in(opr1_in), .opr2_in(opr2_in),
        .rrf_dest_in(rrf_dest_in), .cz_in(cz_in), .cmp_in(cmp_in),
        .carry_in(carry_in), .zero_in(zero_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
        .opcode_out(opcode_out), .rrf_dest_out(rrf_dest_out), .result(result),
        .pc_next(pc_next), .exec_out(exec_out), .illegal_out(illegal_out),
        .carry_out(carry_out), .zero_out(zero_out), .c_wr(c_wr), .z_wr(z_wr)
    );

    typedef struct {
        int pc, op, a, b, dest, cz;
        bit cmp, cin, zin;
    } vec_t;

    typedef struct {
        int pc, op, dest, res, pcn, acc;
        bit exec, ill, cy, zr, cw, zw;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_emit   = 0;
    bit seen_edge;
    exp_t q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what the spec says an instruction must produce, in plain integer arithmetic.
    function automatic exp_t model(input int pc, input int op, input int a, input int b,
                                   input int dest, input int cz, input bit cmp,
                                   input bit cin, input bit zin);
        exp_t e;
        int s;
        e = '{default: 0};
        e.pc   = pc;
        e.op   = op;
        e.dest = dest;
        e.pcn  = (pc + 1) % 65536;
        e.ill  = !(op == 1 || op == 2 || op == 3);
        e.exec = !e.ill && (cz == 0 || cz == 3 || (cz == 1 && zin) || (cz == 2 && cin));
        if (e.exec) begin
            if (op == 1) begin
                s = a + b + ((cz == 3 && cin) ? 1 : 0);
                e.res = s % 65536;
                e.cy  = (s >= 65536);
            end else if (op == 3) begin
                e.res = (a - b + 65536) % 65536;
                e.cy  = (a >= b);
            end else begin
                e.res = 65535 - (a & b);
            end
        end
        e.zr = e.exec && (e.res == 0);
        e.zw = e.exec && cmp;
        e.cw = e.exec && cmp && (op != 2);
        return e;
    endfunction

    function automatic vec_t mk(input int pc, input int op, input int a, input int b,
                                input int dest, input int cz, input bit cmp,
                                input bit cin, input bit zin);
        vec_t v;
        v.pc = pc; v.op = op; v.a = a; v.b = b; v.dest = dest; v.cz = cz;
        v.cmp = cmp; v.cin = cin; v.zin = zin;
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) seen_edge <= 1'b0;
        else      seen_edge <= 1'b1;
    end

    // Scoreboard: one entry per accepted instruction, in issue order.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_ov;
        cyc++;
        if (!rst) begin
            chk("reset_outputs_zero",
                |{out_valid, in_ready, pc_out, opcode_out, rrf_dest_out, result, pc_next,
                  exec_out, illegal_out, carry_out, zero_out, c_wr, z_wr}, 0);
            q.delete();
        end else begin
            chk("in_ready", in_ready, seen_edge && (q.size() < 2 || out_ready));
            exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk("out_valid", out_valid, exp_ov);
            if (out_valid && q.size() > 0) begin
                e = q[0];
                chk("pc_out", pc_out, e.pc);
                chk("opcode_out", opcode_out, e.op);
                chk("rrf_dest_out", rrf_dest_out, e.dest);
                chk("pc_next", pc_next, e.pcn);
                chk("exec_out", exec_out, e.exec);
                chk("illegal_out", illegal_out, e.ill);
                chk("c_wr", c_wr, e.cw);
                chk("z_wr", z_wr, e.zw);
                if (e.exec) begin
                    chk("result", result, e.res);
                    chk("carry_out", carry_out, e.cy);
                    chk("zero_out", zero_out, e.zr);
                end else if (!e.ill) begin
                    chk("result_not_exec", result, 0);
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    n_emit++;
                end
                if (in_valid && in_ready) begin
                    e = model(int'(pc_in), int'(opcode_in), int'(opr1_in), int'(opr2_in),
                              int'(rrf_dest_in), int'(cz_in), cmp_in, carry_in, zero_in);
                    e.acc = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input vec_t v);
        pc_in       = PW'(v.pc);
        opcode_in   = 4'(v.op);
        opr1_in     = DW'(v.a);
        opr2_in     = DW'(v.b);
        rrf_dest_in = TW'(v.dest);
        cz_in       = 2'(v.cz);
        cmp_in      = v.cmp;
        carry_in    = v.cin;
        zero_in     = v.zin;
    endtask

    // Presents one instruction and returns #1 after the edge that accepted it.
    task automatic issue(input vec_t v);
        bit ok;
        ok = 1'b0;
        drive(v);
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("issue_timeout", 0, 1);
    endtask

    vec_t  vtab[10];
    exp_t  pin;
    int    base;
    logic [PW-1:0] held_pc;
    logic [DW-1:0] held_res;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        // model pins against hand-computed values
        pin = model(0, 3, 5, 7, 0, 0, 1, 0, 0);
        chk("pin_sub_borrow_res", pin.res, 'hFFFE);
        chk("pin_sub_borrow_cy", pin.cy, 0);
        pin = model(0, 1, 'h7FFF, 1, 0, 3, 1, 1, 0);
        chk("pin_adc_res", pin.res, 'h8001);
        pin = model(0, 2, 'h0F0F, 'h00FF, 0, 3, 1, 0, 0);
        chk("pin_nand_res", pin.res, 'hFFF0);
        chk("pin_nand_cw", pin.cw, 0);

        repeat (2) @(negedge clk);
        #1 chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        #1 rst = 1'b1;
        #1 chk("in_ready_before_first_edge", in_ready, 0);
        @(posedge clk); #1;
        chk("in_ready_after_first_edge", in_ready, 1);

        // ADD overflow to zero
        issue(mk('h10, 1, 'hFFFF, 1, 3, 0, 1, 0, 0));
        @(posedge clk); #1;
        chk("add_ovf_valid", out_valid, 1);
        chk("add_ovf_result", result, 'h0000);
        chk("add_ovf_carry", carry_out, 1);
        chk("add_ovf_zero", zero_out, 1);
        chk("add_ovf_cwr", c_wr, 1);
        chk("add_ovf_zwr", z_wr, 1);

        // ADZ with zero flag clear: completes without executing
        issue(mk('h20, 1, 5, 6, 7, 1, 1, 0, 0));
        @(posedge clk); #1;
        chk("adz_valid", out_valid, 1);
        chk("adz_exec", exec_out, 0);
        chk("adz_dest", rrf_dest_out, 7);
        chk("adz_cwr", c_wr, 0);
        chk("adz_zwr", z_wr, 0);

        // NAND of all ones
        issue(mk('h30, 2, 'hFFFF, 'hFFFF, 4, 0, 1, 1, 0));
        @(posedge clk); #1;
        chk("nand_result", result, 'h0000);
        chk("nand_zwr", z_wr, 1);
        chk("nand_zero", zero_out, 1);
        chk("nand_cwr", c_wr, 0);

        // illegal opcode with PC wrap
        issue(mk('hFFFF, 5, 1, 2, 9, 0, 1, 0, 0));
        @(posedge clk); #1;
        chk("ill_illegal", illegal_out, 1);
        chk("ill_exec", exec_out, 0);
        chk("ill_pc_next", pc_next, 'h0000);

        // four back-to-back issues while the CDB stalls for three cycles
        repeat (2) @(posedge clk); #1;
        base = n_emit;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    issue(mk('h100 + i, 1 + (i % 3), 'h1000 * (i + 1), 'h0123, 10 + i, 0, 1, 0, 0));
            end
            begin
                repeat (2) @(posedge clk); #1;
                chk("stall_in_ready_low", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
                held_pc  = pc_out;
                held_res = result;
                @(posedge clk); #1;
                chk("stall_pc_stable", pc_out, held_pc);
                chk("stall_result_stable", result, held_res);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        chk("stall_all_emitted", n_emit - base, 4);

        // table of mixed ops with a varying out_ready pattern
        vtab[0] = mk('h200, 3, 7, 5, 1, 0, 1, 0, 0);
        vtab[1] = mk('h201, 3, 5, 7, 2, 0, 0, 0, 0);
        vtab[2] = mk('h202, 1, 'hFFFF, 0, 3, 3, 1, 1, 0);
        vtab[3] = mk('h203, 3, 9, 1, 4, 2, 1, 0, 1);
        vtab[4] = mk('h204, 2, 'h0F0F, 'h00FF, 5, 2, 1, 1, 0);
        vtab[5] = mk('h205, 2, 'h1234, 'hFF00, 6, 3, 1, 0, 0);
        vtab[6] = mk('h206, 0, 1, 1, 7, 0, 1, 0, 0);
        vtab[7] = mk('h207, 15, 1, 1, 8, 0, 1, 0, 0);
        vtab[8] = mk('h208, 1, 'h8000, 'h8000, 9, 1, 1, 0, 1);
        vtab[9] = mk('h209, 3, 'h4444, 'h4444, 11, 3, 1, 1, 0);
        base = n_emit;
        fork
            begin
                for (int i = 0; i < 10; i++) issue(vtab[i]);
            end
            begin
                for (int i = 0; i < 24; i++) begin
                    out_ready = (i % 3) != 1;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;
        chk("table_all_emitted", n_emit - base, 10);

        // flush with both stages full and a third instruction presented
        out_ready = 1'b0;
        issue(mk('h300, 1, 1, 2, 1, 0, 1, 0, 0));
        issue(mk('h301, 1, 3, 4, 2, 0, 1, 0, 0));
        drive(mk('h302, 1, 5, 6, 3, 0, 1, 0, 0));
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        base = n_emit;
        out_ready = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk("flush_nothing_emitted", n_emit - base, 0);
        chk("flush_out_valid_after", out_valid, 0);

        // asynchronous reset with instructions in flight
        out_ready = 1'b0;
        issue(mk('h400, 1, 1, 1, 1, 0, 1, 0, 0));
        issue(mk('h401, 2, 1, 1, 2, 0, 1, 0, 0));
        #2 rst = 1'b0;
        #1 chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_pc_out", pc_out, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        base = n_emit;
        repeat (6) @(posedge clk); #1;
        chk("midrst_nothing_emitted", n_emit - base, 0);

        // pipeline still works after the reset
        issue(mk('h500, 3, 'h0010, 'h0010, 12, 0, 1, 0, 0));
        @(posedge clk); #1;
        chk("post_rst_zero", zero_out, 1);
        chk("post_rst_carry", carry_out, 1);
        repeat (3) @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe_gen.md
ALU_PIPE_GEN -- requirements
Module: alu_pipe_gen

Interface
REQ-001 SHALL take parameter DATA_W, default 16, operand/result width.
REQ-002 SHALL take parameter PC_W, default 16, program-counter width.
REQ-003 SHALL take parameter TAG_W, default 5, RRF destination tag width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1  issue handshake from reservation station.
REQ-007 SHALL have inputs pc_in PC_W, opcode_in 4, opr1_in DATA_W, opr2_in DATA_W, rrf_dest_in TAG_W, cz_in 2, cmp_in 1, carry_in 1, zero_in 1  issued instruction plus renamed flag values.
REQ-008 SHALL have input flush  1  kills all in-flight instructions.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1  CDB handshake.
REQ-010 SHALL have outputs pc_out PC_W, opcode_out 4, rrf_dest_out TAG_W, result DATA_W, pc_next PC_W, exec_out 1, illegal_out 1, carry_out 1, zero_out 1, c_wr 1, z_wr 1.

Function
REQ-011 SHALL be two register stages (S1 issue, S2 output), throughput one per cycle, latency exactly 2 cycles from accepting edge to out_valid when unstalled.
REQ-012 SHALL accept an instruction on an edge where in_valid && in_ready && !flush.
REQ-013 SHALL advance S2 when !out_valid || out_ready; S1 when S1 empty or S2 advances; in_ready = !S1_valid || S1 advancing.
REQ-014 SHALL hold all S2 outputs stable while out_valid && !out_ready.
REQ-015 SHALL decode opcode 0001 ADD, 0010 NAND, 0011 SUB (opr1 - opr2); others illegal.
REQ-016 SHALL decode cz 00 unconditional, 01 execute iff zero_in, 10 execute iff carry_in, 11 for ADD only: opr1+opr2+carry_in unconditional; cz 11 on NAND/SUB treated as 00.
REQ-017 SHALL compute ADD/SUB in DATA_W+1 bits; carry_out = bit DATA_W (SUB: 1 means no borrow); result = low DATA_W bits, wrap-around modulo 2^DATA_W.
REQ-018 SHALL set zero_out = (result == 0) for every executed op.
REQ-019 SHALL assert z_wr = exec && cmp; c_wr = exec && cmp && opcode is ADD or SUB; NAND never writes carry.
REQ-020 SHALL, for condition-false instructions, still complete: out_valid=1, exec_out=0, result=0, c_wr=z_wr=0.
REQ-021 SHALL, for illegal opcodes, complete with illegal_out=1, exec_out=0, c_wr=z_wr=0.
REQ-022 SHALL drive pc_next = pc + 1 modulo 2^PC_W; pc_out, opcode_out, rrf_dest_out pass through unchanged.
REQ-023 SHALL take flags only from carry_in/zero_in; no internal flag state.
REQ-024 SHALL on flush clear S1 and S2 valid at that edge; flush has priority over capture, advance and stall; the instruction presented that cycle is dropped.

Reset
REQ-025 SHALL on rst low asynchronously clear both stage valids and drive every output (including out_valid, in_ready held deasserted) to 0 until first edge after release.
REQ-026 SHALL discard in-flight instructions on mid-operation reset; none emitted afterwards.

Structure
REQ-027 SHALL place opcode codes (ADD/NAND/SUB) and cz mode codes in shared package alu_pkg.
REQ-028 SHALL isolate combinational compute (decode, condition, add/sub/nand, flags) in sub-module alu_core, instantiated between S1 and S2.

Verification
REQ-029 ADD 0xFFFF+0x0001, cz=00, cmp=1 -> 2 cycles later result=0x0000, carry_out=1, zero_out=1, c_wr=z_wr=1.
REQ-030 ADZ with zero_in=0, rrf_dest=7 -> out_valid=1, exec_out=0, rrf_dest_out=7, c_wr=z_wr=0.
REQ-031 NAND 0xFFFF,0xFFFF cmp=1 -> result=0x0000, z_wr=1, zero_out=1, c_wr=0.
REQ-032 Back-to-back 4 issues, out_ready low 3 cycles -> in_ready drops after S1/S2 fill, outputs stable, all 4 emitted in order, none lost.
REQ-033 flush with S1, S2 full and in_valid high -> next cycle out_valid=0, nothing emitted for the 3 instructions.
REQ-034 opcode 0101, pc=0xFFFF -> illegal_out=1, exec_out=0, pc_next=0x0000.
